// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM mux/demux pair: default sizing, FSM states and
// a constant-function clog2 usable in parameter declarations.
package tdm_pkg;
  localparam int TDM_N = 4;
  localparam int TDM_W = 1;

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} tdm_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/tdm_slot_ctr.sv
// Mod-N slot counter. Clear wins over load-to-1, which wins over increment.
module tdm_slot_ctr
  import tdm_pkg::*;
#(
  parameter int N  = TDM_N,
  parameter int SW = clog2(TDM_N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          load1_i,
  input  logic          inc_i,
  output logic [SW-1:0] cnt_o
);
  localparam logic [SW-1:0] LAST = SW'(N - 1);

  logic [SW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)        cnt_d = '0;
    else if (load1_i) cnt_d = SW'(1);
    else if (inc_i)   cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/tdm_demux.sv
// TDM receive demultiplexer: locks on frame_sync at slot 0, collects N slot words
// into a work buffer and publishes each completed frame as one registered bundle.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int N  = TDM_N,
  parameter int W  = TDM_W,
  localparam int SW = clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   din,
  input  logic           din_valid,
  input  logic           frame_sync,
  output logic [N*W-1:0] ch_data,
  output logic           frame_valid,
  output logic           sync_err,
  output logic           locked,
  output logic [SW-1:0]  slot
);
  localparam logic [SW-1:0] LAST = SW'(N - 1);

  tdm_state_e            state_q, state_d;
  logic [N-1:0][W-1:0]   work_q, work_d;
  logic [N-1:0][W-1:0]   ch_q, ch_d;
  logic                  fv_q, fv_d, se_q, se_d;
  logic                  clr, load1, inc;
  logic [SW-1:0]         slot_q;

  tdm_slot_ctr #(.N(N), .SW(SW)) u_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr),
    .load1_i (load1),
    .inc_i   (inc),
    .cnt_o   (slot_q)
  );

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    ch_d    = ch_q;
    fv_d    = 1'b0;
    se_d    = 1'b0;
    clr     = 1'b0;
    load1   = 1'b0;
    inc     = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (frame_sync) begin
            work_d[0] = din;
            load1     = 1'b1;
            state_d   = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync) begin
            // Sync mid-frame abandons the partial frame and restarts on this word.
            se_d      = (slot_q != '0);
            work_d[0] = din;
            load1     = 1'b1;
          end else if (slot_q == '0) begin
            se_d    = 1'b1;
            clr     = 1'b1;
            state_d = HUNT;
          end else begin
            work_d[slot_q] = din;
            if (slot_q == LAST) begin
              ch_d = work_d;
              fv_d = 1'b1;
              clr  = 1'b1;
            end else begin
              inc = 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      work_q  <= '0;
      ch_q    <= '0;
      fv_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      ch_q    <= ch_d;
      fv_q    <= fv_d;
      se_q    <= se_d;
    end
  end

  assign ch_data     = ch_q;
  assign frame_valid = fv_q;
  assign sync_err    = se_q;
  assign locked      = (state_q == LOCKED);
  assign slot        = slot_q;
endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: an N=4/W=1 and an N=3/W=8 instance, each tracked by a
// frame-level model checked every cycle, plus literal expectations per scenario.
module tb_tdm_demux;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        din_a = 1'b0, vld_a = 1'b0, sync_a = 1'b0;
  logic [3:0]  ch_a;
  logic        fv_a, se_a, lk_a;
  logic [1:0]  slot_a;

  logic [7:0]  din_b = 8'h00;
  logic        vld_b = 1'b0, sync_b = 1'b0;
  logic [23:0] ch_b;
  logic        fv_b, se_b, lk_b;
  logic [1:0]  slot_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tdm_demux #(.N(4), .W(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din_a), .din_valid(vld_a), .frame_sync(sync_a),
    .ch_data(ch_a), .frame_valid(fv_a), .sync_err(se_a), .locked(lk_a), .slot(slot_a)
  );

  tdm_demux #(.N(3), .W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .din_valid(vld_b), .frame_sync(sync_b),
    .ch_data(ch_b), .frame_valid(fv_b), .sync_err(se_b), .locked(lk_b), .slot(slot_b)
  );

  // Frame-level model: what each receiver must be showing after a given valid word.
  typedef struct packed {
    bit              lock;
    int              slot;
    logic [3:0][7:0] work;
    logic [3:0][7:0] ch;
    bit              fv;
    bit              se;
  } mdl_t;

  function automatic mdl_t step(input mdl_t m, input int n, input logic [7:0] d,
                                input bit v, input bit s);
    mdl_t r;
    r = m;
    r.fv = 1'b0;
    r.se = 1'b0;
    if (!v) return r;
    if (!r.lock) begin
      if (s) begin r.work[0] = d; r.slot = 1; r.lock = 1'b1; end
    end else if (s) begin
      r.se = (r.slot != 0);
      r.work[0] = d;
      r.slot = 1;
    end else if (r.slot == 0) begin
      r.se = 1'b1;
      r.lock = 1'b0;
    end else begin
      r.work[r.slot] = d;
      if (r.slot == n - 1) begin
        for (int k = 0; k < n; k++) r.ch[k] = r.work[k];
        r.fv = 1'b1;
        r.slot = 0;
      end else begin
        r.slot = r.slot + 1;
      end
    end
    return r;
  endfunction

  mdl_t ma, mb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '0;
      mb <= '0;
    end else begin
      ma <= step(ma, 4, {7'b0, din_a}, vld_a, sync_a);
      mb <= step(mb, 3, din_b, vld_b, sync_b);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("A.ch",    {28'b0, ch_a},
          {28'b0, ma.ch[3][0], ma.ch[2][0], ma.ch[1][0], ma.ch[0][0]});
      chk("A.fv",    {31'b0, fv_a},   {31'b0, ma.fv});
      chk("A.se",    {31'b0, se_a},   {31'b0, ma.se});
      chk("A.lock",  {31'b0, lk_a},   {31'b0, ma.lock});
      chk("A.slot",  {30'b0, slot_a}, ma.slot);
      chk("B.ch",    {8'b0, ch_b},    {8'b0, mb.ch[2], mb.ch[1], mb.ch[0]});
      chk("B.fv",    {31'b0, fv_b},   {31'b0, mb.fv});
      chk("B.se",    {31'b0, se_b},   {31'b0, mb.se});
      chk("B.lock",  {31'b0, lk_b},   {31'b0, mb.lock});
      chk("B.slot",  {30'b0, slot_b}, mb.slot);
    end
  end

  // Drivers: called at a negedge, hold the word for one cycle, return at the next negedge.
  task automatic va(input logic d, input logic s);
    din_a = d; vld_a = 1'b1; sync_a = s;
    @(negedge clk);
    vld_a = 1'b0; sync_a = 1'b0;
  endtask

  task automatic vb(input logic [7:0] d, input logic s);
    din_b = d; vld_b = 1'b1; sync_b = s;
    @(negedge clk);
    vld_b = 1'b0; sync_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst.chA",  {28'b0, ch_a}, 32'h0);
    chk("rst.lkA",  {31'b0, lk_a}, 32'h0);
    chk("rst.slA",  {30'b0, slot_a}, 32'h0);
    chk("rst.chB",  {8'b0, ch_b}, 32'h0);
    rst_n = 1'b1;
    idle(2);
    chk("idle.fv",  {31'b0, fv_a}, 32'h0);
    chk("idle.se",  {31'b0, se_a}, 32'h0);

    // Back-to-back frame 1,1,0,1
    va(1'b1, 1'b1); va(1'b1, 1'b0); va(1'b0, 1'b0); va(1'b1, 1'b0);
    chk("f1.ch",   {28'b0, ch_a}, 32'hB);
    chk("f1.fv",   {31'b0, fv_a}, 32'h1);
    chk("f1.slot", {30'b0, slot_a}, 32'h0);
    chk("f1.lock", {31'b0, lk_a}, 32'h1);
    idle(1);
    chk("f1.fv_drop", {31'b0, fv_a}, 32'h0);

    // Same structure with gaps: 0,1,1,0
    va(1'b0, 1'b1); idle(2); va(1'b1, 1'b0); idle(1); va(1'b1, 1'b0); idle(3);
    chk("gap.hold", {28'b0, ch_a}, 32'hB);
    va(1'b0, 1'b0);
    chk("gap.ch",  {28'b0, ch_a}, 32'h6);
    chk("gap.fv",  {31'b0, fv_a}, 32'h1);
    idle(2);

    // Early sync at slot 2, then the restarted frame 1,1,1,0
    va(1'b1, 1'b1); va(1'b0, 1'b0); va(1'b1, 1'b1);
    chk("early.se", {31'b0, se_a}, 32'h1);
    chk("early.fv", {31'b0, fv_a}, 32'h0);
    chk("early.ch", {28'b0, ch_a}, 32'h6);
    va(1'b1, 1'b0); va(1'b1, 1'b0); va(1'b0, 1'b0);
    chk("early.new", {28'b0, ch_a}, 32'h7);

    // Missing sync at slot 0
    va(1'b1, 1'b0);
    chk("miss.se",   {31'b0, se_a}, 32'h1);
    chk("miss.lock", {31'b0, lk_a}, 32'h0);
    va(1'b1, 1'b0); va(1'b0, 1'b0);
    chk("hunt.se",   {31'b0, se_a}, 32'h0);
    chk("hunt.slot", {30'b0, slot_a}, 32'h0);
    va(1'b0, 1'b1);
    chk("relock",    {31'b0, lk_a}, 32'h1);
    chk("relock.sl", {30'b0, slot_a}, 32'h1);

    // Async reset mid-frame at slot 2
    va(1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.ch",   {28'b0, ch_a}, 32'h0);
    chk("arst.lock", {31'b0, lk_a}, 32'h0);
    chk("arst.slot", {30'b0, slot_a}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // N=3, W=8 instance
    vb(8'hA5, 1'b1); vb(8'h5A, 1'b0); vb(8'hC3, 1'b0);
    chk("B.f1",    {8'b0, ch_b}, 32'h00C35AA5);
    chk("B.f1.fv", {31'b0, fv_b}, 32'h1);
    chk("B.wrap",  {30'b0, slot_b}, 32'h0);
    vb(8'h11, 1'b1); vb(8'h22, 1'b1);
    chk("B.early", {31'b0, se_b}, 32'h1);
    vb(8'h33, 1'b0); idle(1); vb(8'h44, 1'b0);
    chk("B.f2",    {8'b0, ch_b}, 32'h00443322);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
